// File: rtl/uart_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl_if
// Read-side connection between a show-ahead RX FIFO and its consumer.
//   fifo_empty  FIFO has no byte at its head
//   fifo_rdata  head byte, valid whenever fifo_empty=0
//   fifo_pop    1-cycle strobe from the consumer that removes the head byte
// Modports:
//   master  the consumer (pops bytes)
//   slave   the FIFO (provides bytes)
// ---------------------------------------------------------------------------
interface uart_cmd_ctrl_if;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_pop;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_pop
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_pop
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
// Command sequencer between the UART RX FIFO and the counter/FND datapath.
// Drains bytes from a show-ahead FIFO, decodes case-insensitive ASCII commands
// and drives the counter controls:
//   R  toggle run     C  clear pulse     U  count up     D  count down
//   S  load command: exactly 4 decimal digits followed by CR
// CR and LF are ignored between commands; anything else raises cmd_err.
// A load command that stalls for TIMEOUT_CYC empty cycles is abandoned.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   fifo         uart_cmd_ctrl_if.master (fifo_empty, fifo_rdata, fifo_pop)
//   run          counter run enable (level)
//   dir          count direction, 0=up 1=down (level)
//   clear_pulse  1-cycle counter clear
//   load_pulse   1-cycle counter load of load_value
//   load_value   value to load, held until the next successful load
//   cmd_err      1-cycle pulse on a bad byte, bad digit, missing CR or timeout
//   busy         1 while a load command is being collected
// All control outputs are registered: a byte's effect shows the cycle after
// it is popped.
// ---------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int CNT_W       = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_cmd_ctrl_if.master      fifo,
  output logic                 run,
  output logic                 dir,
  output logic                 clear_pulse,
  output logic                 load_pulse,
  output logic [CNT_W-1:0]     load_value,
  output logic                 cmd_err,
  output logic                 busy
);

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIGITS,
    TERM
  } state_t;

  state_t             state, state_n;
  logic               run_n, dir_n, clear_n, load_n, err_n, busy_n;
  logic [CNT_W-1:0]   load_value_n;
  logic [CNT_W-1:0]   acc, acc_n;
  logic [1:0]         dig_cnt, dig_cnt_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;

  logic               pop;
  logic               is_digit;
  logic [CNT_W+3:0]   acc_x10;
  logic [CNT_W-1:0]   acc_digit;

  // The FIFO is show-ahead, so a byte is consumed as soon as one is present;
  // popping is held off during reset so nothing is lost while rst is high.
  assign pop           = !fifo.fifo_empty && !rst;
  assign fifo.fifo_pop = pop;

  assign is_digit  = (fifo.fifo_rdata >= "0") && (fifo.fifo_rdata <= "9");
  assign acc_x10   = acc * 4'd10;
  // Four digits top out at 9999, so the truncation to CNT_W never drops bits.
  assign acc_digit = acc_x10[CNT_W-1:0] + CNT_W'(fifo.fifo_rdata[3:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      run         <= 1'b0;
      dir         <= 1'b0;
      clear_pulse <= 1'b0;
      load_pulse  <= 1'b0;
      load_value  <= '0;
      cmd_err     <= 1'b0;
      busy        <= 1'b0;
      acc         <= '0;
      dig_cnt     <= '0;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_n;
      run         <= run_n;
      dir         <= dir_n;
      clear_pulse <= clear_n;
      load_pulse  <= load_n;
      load_value  <= load_value_n;
      cmd_err     <= err_n;
      busy        <= busy_n;
      acc         <= acc_n;
      dig_cnt     <= dig_cnt_n;
      tmo_cnt     <= tmo_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    run_n        = run;
    dir_n        = dir;
    clear_n      = 1'b0;
    load_n       = 1'b0;
    err_n        = 1'b0;
    load_value_n = load_value;
    acc_n        = acc;
    dig_cnt_n    = dig_cnt;
    tmo_cnt_n    = tmo_cnt;

    case (state)
      IDLE: begin
        tmo_cnt_n = '0;
        if (pop) begin
          case (fifo.fifo_rdata)
            "R", "r": run_n   = ~run;
            "C", "c": clear_n = 1'b1;
            "U", "u": dir_n   = 1'b0;
            "D", "d": dir_n   = 1'b1;
            "S", "s": begin
              state_n   = DIGITS;
              dig_cnt_n = '0;
              acc_n     = '0;
            end
            8'h0D, 8'h0A: ;
            default: err_n = 1'b1;
          endcase
        end
      end

      DIGITS: begin
        if (pop) begin
          tmo_cnt_n = '0;
          if (is_digit) begin
            acc_n     = acc_digit;
            dig_cnt_n = dig_cnt + 2'd1;
            if (dig_cnt == 2'd3) state_n = TERM;
          end else begin
            err_n   = 1'b1;
            acc_n   = '0;
            state_n = IDLE;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_n     = 1'b1;
          tmo_cnt_n = '0;
          state_n   = IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end

      TERM: begin
        if (pop) begin
          tmo_cnt_n = '0;
          state_n   = IDLE;
          // A wrong terminator is consumed here rather than re-decoded as a
          // new command.
          if (fifo.fifo_rdata == 8'h0D) begin
            load_value_n = acc;
            load_n       = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_n     = 1'b1;
          tmo_cnt_n = '0;
          state_n   = IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctrl
// Bench for uart_cmd_ctrl. A queue models the show-ahead RX FIFO. Every
// expected output event (run/dir/busy change, clear, load, error) is queued
// when stimulus is issued; a negedge monitor pops and compares each event the
// DUT produces, including its latency in cycles from the last FIFO pop.
// ---------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 14;

  localparam int EV_RUN  = 1;
  localparam int EV_DIR  = 2;
  localparam int EV_BUSY = 3;
  localparam int EV_CLR  = 4;
  localparam int EV_LOAD = 5;
  localparam int EV_ERR  = 6;

  typedef struct {
    int kind;
    int value;
    int gap;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run, dir, clear_pulse, load_pulse, cmd_err, busy;
  logic [CNT_W-1:0] load_value;

  logic             tb_empty = 1'b1;
  logic [7:0]       tb_rdata = 8'h00;

  byte unsigned     rxq[$];
  exp_t             expq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int last_pop = 0;
  int pop_cnt  = 0;

  logic prev_run = 1'b0, prev_dir = 1'b0, prev_busy = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_ctrl_if ifc ();
  assign ifc.fifo_empty = tb_empty;
  assign ifc.fifo_rdata = tb_rdata;

  uart_cmd_ctrl #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo        (ifc),
    .run         (run),
    .dir         (dir),
    .clear_pulse (clear_pulse),
    .load_pulse  (load_pulse),
    .load_value  (load_value),
    .cmd_err     (cmd_err),
    .busy        (busy)
  );

  task automatic check_output(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic string kind_name(input int kind);
    case (kind)
      EV_RUN:  return "run";
      EV_DIR:  return "dir";
      EV_BUSY: return "busy";
      EV_CLR:  return "clear_pulse";
      EV_LOAD: return "load_pulse";
      EV_ERR:  return "cmd_err";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_evt(input int kind, input int value, input int gap);
    exp_t e;
    e.kind  = kind;
    e.value = value;
    e.gap   = gap;
    expq.push_back(e);
  endtask

  // Compare one DUT event against the head of the scoreboard.
  task automatic observe(input int kind, input int value);
    exp_t e;
    if (expq.size() == 0) begin
      check_output({"unexpected_", kind_name(kind)}, kind, 0);
    end else begin
      e = expq.pop_front();
      check_output("event_kind", kind, e.kind);
      check_output({kind_name(e.kind), "_value"}, value, e.value);
      check_output({kind_name(e.kind), "_latency"}, cycle - last_pop, e.gap);
    end
  endtask

  task automatic apply_stimulus(input string s);
    @(posedge clk);
    #1;
    for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
  endtask

  // Wait, bounded, for the FIFO and the scoreboard to empty, then idle a few
  // cycles so any stray event still gets seen by the monitor.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((rxq.size() != 0 || expq.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_output({tag, "_pending"}, rxq.size() + expq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // FIFO pop side: consume the head byte on every strobe.
  always @(posedge clk) begin
    cycle++;
    if (ifc.fifo_pop) begin
      check_output("pop_nonempty", int'(tb_empty), 0);
      last_pop = cycle;
      pop_cnt++;
      if (rxq.size() != 0) void'(rxq.pop_front());
    end
  end

  // FIFO head refresh plus output event monitor.
  always @(negedge clk) begin
    tb_empty = (rxq.size() == 0);
    tb_rdata = (rxq.size() == 0) ? 8'h00 : rxq[0];
    if (!rst) begin
      if (run != prev_run)   observe(EV_RUN, int'(run));
      if (dir != prev_dir)   observe(EV_DIR, int'(dir));
      if (busy != prev_busy) observe(EV_BUSY, int'(busy));
      if (clear_pulse || load_pulse || cmd_err) begin
        check_output("pulse_onehot", int'(clear_pulse) + int'(load_pulse) + int'(cmd_err), 1);
        if (clear_pulse) observe(EV_CLR, 0);
        if (load_pulse)  observe(EV_LOAD, int'(load_value));
        if (cmd_err)     observe(EV_ERR, 0);
      end
    end
    prev_run  = run;
    prev_dir  = dir;
    prev_busy = busy;
  end

  task automatic check_all_zero(input string tag);
    check_output({tag, "_run"}, int'(run), 0);
    check_output({tag, "_dir"}, int'(dir), 0);
    check_output({tag, "_busy"}, int'(busy), 0);
    check_output({tag, "_clear"}, int'(clear_pulse), 0);
    check_output({tag, "_load"}, int'(load_pulse), 0);
    check_output({tag, "_err"}, int'(cmd_err), 0);
    check_output({tag, "_load_value"}, int'(load_value), 0);
    check_output({tag, "_fifo_pop"}, int'(ifc.fifo_pop), 0);
  endtask

  initial begin
    int pops0;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Run toggles on and off, one pop per byte.
    pops0 = pop_cnt;
    expect_evt(EV_RUN, 1, 0);
    apply_stimulus("R");
    drain("run_on");
    check_output("run_on_level", int'(run), 1);
    expect_evt(EV_RUN, 0, 0);
    apply_stimulus("r");
    drain("run_off");
    check_output("run_off_level", int'(run), 0);
    check_output("run_pops", pop_cnt - pops0, 2);

    // Direction then clear, back-to-back bytes.
    pops0 = pop_cnt;
    expect_evt(EV_DIR, 1, 0);
    expect_evt(EV_CLR, 0, 0);
    apply_stimulus("DC");
    drain("dir_clear");
    check_output("dir_level", int'(dir), 1);
    check_output("dir_clear_pops", pop_cnt - pops0, 2);

    // Stray CR/LF are silent; full load command.
    pops0 = pop_cnt;
    expect_evt(EV_BUSY, 1, 0);
    expect_evt(EV_BUSY, 0, 0);
    expect_evt(EV_LOAD, 427, 0);
    apply_stimulus("\r\nS0427\r");
    drain("load427");
    check_output("load427_value", int'(load_value), 427);
    check_output("load427_pops", pop_cnt - pops0, 8);
    check_output("load427_dir_kept", int'(dir), 1);

    // Bad digit aborts, load_value untouched; unknown byte errors.
    expect_evt(EV_BUSY, 1, 0);
    expect_evt(EV_BUSY, 0, 0);
    expect_evt(EV_ERR, 0, 0);
    apply_stimulus("s12x");
    drain("bad_digit");
    check_output("bad_digit_load_value", int'(load_value), 427);
    expect_evt(EV_ERR, 0, 0);
    apply_stimulus("Z");
    drain("bad_byte");

    // Wrong terminator after four digits.
    expect_evt(EV_BUSY, 1, 0);
    expect_evt(EV_BUSY, 0, 0);
    expect_evt(EV_ERR, 0, 0);
    apply_stimulus("S1234x");
    drain("bad_term");
    check_output("bad_term_load_value", int'(load_value), 427);

    // Stall mid-command: error after TIMEOUT_CYC empty cycles.
    expect_evt(EV_BUSY, 1, 0);
    expect_evt(EV_BUSY, 0, TIMEOUT_CYC);
    expect_evt(EV_ERR, 0, TIMEOUT_CYC);
    apply_stimulus("S99");
    drain("timeout");
    check_output("timeout_dir_kept", int'(dir), 1);

    // Max value, lowercase start, and back to counting up.
    expect_evt(EV_BUSY, 1, 0);
    expect_evt(EV_BUSY, 0, 0);
    expect_evt(EV_LOAD, 9999, 0);
    expect_evt(EV_DIR, 0, 0);
    apply_stimulus("s9999\ru");
    drain("load9999");
    check_output("load9999_value", int'(load_value), 9999);

    // Reset in the middle of a load command.
    expect_evt(EV_DIR, 1, 0);
    expect_evt(EV_BUSY, 1, 0);
    apply_stimulus("DS5");
    drain("pre_reset");
    check_output("pre_reset_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_evt(EV_BUSY, 1, 0);
    expect_evt(EV_BUSY, 0, 0);
    expect_evt(EV_LOAD, 1, 0);
    for (int i = 0; i < 6; i++) rxq.push_back(i == 0 ? 8'h53 : (i == 5 ? 8'h0D : (i == 4 ? 8'h31 : 8'h30)));
    @(negedge clk);
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drain("post_reset");
    check_output("post_reset_load_value", int'(load_value), 1);
    check_output("post_reset_dir", int'(dir), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
